scan_sequencer: RTL and testbench
=================================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8, giving the width of the dwell input.
REQ-002 The block SHALL have parameter BLANK_CYC, default 1 (legal 1..15), giving the number of en-low cycles between channels.
REQ-003 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, request to begin a scan; sampled only in IDLE.
REQ-006 The block SHALL have port stop, input, 1, synchronous abort to IDLE.
REQ-007 The block SHALL have port continuous, input, 1: 1 repeats frames, 0 runs one frame.
REQ-008 The block SHALL have port mask, input, 4, channel enables; bit i enables channel i.
REQ-009 The block SHALL have port dwell, input, DWELL_W, en-high cycles per channel.
REQ-010 The block SHALL have port A, output, 1, channel select MSB, driving the 2x4 decoder A input.
REQ-011 The block SHALL have port B, output, 1, channel select LSB, driving the 2x4 decoder B input.
REQ-012 The block SHALL have port en, output, 1, decoder enable.
REQ-013 The block SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-014 The block SHALL have port frame_done, output, 1, one-cycle pulse at the end of each frame.

Function
REQ-015 All outputs SHALL be registered, and channel encoding SHALL be {A,B} = channel index, so that channel 0 selects D0 and channel 3 selects D3.
REQ-016 The FSM SHALL have exactly three states: IDLE, SCAN and BLANK.
REQ-017 In IDLE: en=0, A=0, B=0 and busy=0.
REQ-018 In SCAN: en=1 and {A,B} equals the current channel.
REQ-019 In BLANK: en=0 and {A,B} holds the current channel.
REQ-020 In IDLE, a start with mask!=0 and stop=0 SHALL latch mask and dwell, then enter SCAN on the lowest-indexed enabled channel.
REQ-021 On the REQ-020 start, en SHALL rise in the cycle after start is sampled.
REQ-022 In IDLE, a start with mask==0 SHALL be ignored, and the block SHALL remain in IDLE.
REQ-023 SCAN SHALL last exactly max(latched dwell,1) cycles, so dwell=0 is treated as 1; a down-counter of DWELL_W bits SHALL implement this.
REQ-024 SCAN SHALL then enter BLANK for exactly BLANK_CYC cycles.
REQ-025 After BLANK, the channel SHALL advance to the next higher enabled channel in the latched mask.
REQ-026 If no higher enabled channel exists, the frame is complete: the channel wraps to the lowest enabled channel (3 -> 0 search wrap).
REQ-027 At frame completion with continuous=1, the block SHALL re-latch mask and dwell and enter SCAN.
REQ-028 If the re-latched mask is 0 at frame completion, the block SHALL enter IDLE instead.
REQ-029 At frame completion with continuous=0, the block SHALL enter IDLE.
REQ-030 frame_done SHALL be high for exactly one cycle: the first cycle after the final BLANK cycle of a frame, coincident with the next SCAN or IDLE state.
REQ-031 stop=1 in any state SHALL force IDLE on the next edge, with en=0, {A,B}=0 and busy=0.
REQ-032 A stop SHALL NOT produce a frame_done pulse.
REQ-033 When start and stop are asserted in the same cycle, stop SHALL win.
REQ-034 start asserted while busy=1 SHALL be ignored.
REQ-035 Changes to mask or dwell while busy SHALL have no effect until the next frame boundary or start.
REQ-036 en SHALL never be high in two consecutive cycles with different {A,B} values, so that no decoder glitch occurs between channels.

Reset
REQ-037 rst_n=0 SHALL immediately force IDLE, regardless of clk, with A=0, B=0, en=0, busy=0 and frame_done=0.
REQ-038 On rst_n=0, the dwell counter, blank counter and latched mask/dwell SHALL clear to 0.
REQ-039 Reset asserted mid-SCAN SHALL drop en without waiting for a clock edge.
REQ-040 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-041 The bench SHALL cover: mask=1111, dwell=2, BLANK_CYC=1, continuous=0, start pulse -> en pattern 1,1,0 on channels 0,1,2,3 in order (12 cycles), frame_done once in the cycle busy falls, then IDLE.
REQ-042 The bench SHALL cover: mask=1010, dwell=3, continuous=1 -> channels 1,3,1,3... each with en high for 3 cycles, and frame_done pulses every 8 cycles.
REQ-043 The bench SHALL cover: mask=0000 with start -> busy stays 0 and en stays 0.
REQ-044 The bench SHALL cover: dwell=0, mask=0100 -> en high for 1 cycle with {A,B}=10, then 1 blank cycle, then frame_done.
REQ-045 The bench SHALL cover: stop asserted on the 2nd SCAN cycle of channel 1 -> the next cycle shows en=0, {A,B}=00 and busy=0, with no frame_done; a start in the same cycle as stop has no effect.
REQ-046 The bench SHALL cover: rst_n pulsed low mid-SCAN, between clock edges -> en, busy, A and B go 0 immediately; after release the block remains IDLE until start.

Source files
------------

// File: rtl/scan_sequencer.sv
// Channel scan sequencer for a 2x4 decoder: walks the enabled channels of a
// latched mask, holding en high for a dwell time and low for a blanking gap.
module scan_sequencer #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [3:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               A,
  output logic               B,
  output logic               en,
  output logic               busy,
  output logic               frame_done
);

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;

  localparam logic [3:0]         BLANK_LAST = 4'(BLANK_CYC - 1);
  localparam logic [DWELL_W-1:0] ONE        = DWELL_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         ch_q, ch_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [3:0]         bcnt_q, bcnt_d;
  logic [3:0]         mask_lat_q, mask_lat_d;
  logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
  logic               a_q, a_d, b_q, b_d, en_q, en_d, busy_q, busy_d, fd_q, fd_d;

  function automatic logic [1:0] lowest_ch(input logic [3:0] m);
    lowest_ch = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) lowest_ch = 2'(i);
  endfunction

  function automatic logic has_higher(input logic [3:0] m, input logic [1:0] c);
    has_higher = 1'b0;
    for (int i = 0; i < 4; i++)
      if (m[i] && i > int'(c)) has_higher = 1'b1;
  endfunction

  function automatic logic [1:0] next_higher(input logic [3:0] m, input logic [1:0] c);
    next_higher = c;
    for (int i = 3; i >= 0; i--)
      if (m[i] && i > int'(c)) next_higher = 2'(i);
  endfunction

  // Counter counts down to zero, so a dwell of N loads N-1; zero behaves like one.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    dwell_load = (d == '0) ? '0 : d - ONE;
  endfunction

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    dcnt_d      = dcnt_q;
    bcnt_d      = bcnt_q;
    mask_lat_d  = mask_lat_q;
    dwell_lat_d = dwell_lat_q;
    fd_d        = 1'b0;
    if (stop) begin
      state_d = IDLE;
      ch_d    = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && mask != 4'd0) begin
            mask_lat_d  = mask;
            dwell_lat_d = dwell;
            ch_d        = lowest_ch(mask);
            dcnt_d      = dwell_load(dwell);
            state_d     = SCAN;
          end
        end
        SCAN: begin
          if (dcnt_q == '0) begin
            bcnt_d  = BLANK_LAST;
            state_d = BLANK;
          end else begin
            dcnt_d = dcnt_q - ONE;
          end
        end
        BLANK: begin
          if (bcnt_q != 4'd0) begin
            bcnt_d = bcnt_q - 4'd1;
          end else if (has_higher(mask_lat_q, ch_q)) begin
            ch_d    = next_higher(mask_lat_q, ch_q);
            dcnt_d  = dwell_load(dwell_lat_q);
            state_d = SCAN;
          end else begin
            // End of frame: optionally pick up fresh mask/dwell and go again.
            fd_d = 1'b1;
            if (continuous) begin
              mask_lat_d  = mask;
              dwell_lat_d = dwell;
            end
            if (continuous && mask != 4'd0) begin
              ch_d    = lowest_ch(mask);
              dcnt_d  = dwell_load(dwell);
              state_d = SCAN;
            end else begin
              ch_d    = 2'd0;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          ch_d    = 2'd0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they come straight off flops.
    en_d   = (state_d == SCAN);
    busy_d = (state_d != IDLE);
    a_d    = ch_d[1];
    b_d    = ch_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= 2'd0;
      dcnt_q      <= '0;
      bcnt_q      <= 4'd0;
      mask_lat_q  <= 4'd0;
      dwell_lat_q <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dcnt_q      <= dcnt_d;
      bcnt_q      <= bcnt_d;
      mask_lat_q  <= mask_lat_d;
      dwell_lat_q <= dwell_lat_d;
      a_q         <= a_d;
      b_q         <= b_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      fd_q        <= fd_d;
    end
  end

  assign A          = a_q;
  assign B          = b_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: a frame-level queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_scan_sequencer;
  localparam int DWELL_W   = 8;
  localparam int BLANK_CYC = 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               continuous = 1'b0;
  logic [3:0]         mask = 4'd0;
  logic [DWELL_W-1:0] dwell = '0;
  logic               A, B, en, busy, frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .mask(mask), .dwell(dwell), .A(A), .B(B), .en(en), .busy(busy),
    .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue holding one {en,ch} entry per remaining cycle of the frame.
  logic [2:0] mq[$];
  logic       m_fd = 1'b0;
  logic [2:0] m_drop;

  function automatic void push_frame(input logic [3:0] m, input logic [DWELL_W-1:0] d);
    int n;
    n = (d == '0) ? 1 : int'(d);
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        for (int k = 0; k < n; k++) mq.push_back({1'b1, 2'(c)});
        for (int k = 0; k < BLANK_CYC; k++) mq.push_back({1'b0, 2'(c)});
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_fd = 1'b0;
    end else begin
      m_fd = 1'b0;
      if (stop) begin
        mq.delete();
      end else if (mq.size() == 0) begin
        if (start && mask != 4'd0) push_frame(mask, dwell);
      end else begin
        m_drop = mq.pop_front();
        if (mq.size() == 0) begin
          m_fd = 1'b1;
          if (continuous && mask != 4'd0) push_frame(mask, dwell);
        end
      end
    end
  end

  logic       exp_en, exp_busy, prev_en = 1'b0;
  logic [1:0] exp_ch, prev_ch = 2'd0;

  always @(negedge clk) begin
    exp_busy = (mq.size() != 0);
    exp_en   = exp_busy ? mq[0][2] : 1'b0;
    exp_ch   = exp_busy ? mq[0][1:0] : 2'd0;
    chk("model_en", en, exp_en);
    chk("model_ch", {A, B}, exp_ch);
    chk("model_busy", busy, exp_busy);
    chk("model_frame_done", frame_done, m_fd);
    if (en && prev_en) chk("no_glitch_ch", {A, B}, prev_ch);
    prev_en = en;
    prev_ch = {A, B};
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  int fd_pos[$];
  int waited;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_en", en, 0);
    chk("reset_ab", {A, B}, 0);
    chk("reset_fd", frame_done, 0);
    rst_n = 1'b1;
    tick();

    // Full mask, dwell 2, single frame; inputs change mid-frame with no effect.
    mask = 4'b1111; dwell = 8'd2; continuous = 1'b0;
    pulse_start();
    mask = 4'b0000; dwell = 8'd7;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t1_en", en, (i % 3 != 2) ? 1 : 0);
      chk("t1_ch", {A, B}, i / 3);
      chk("t1_busy", busy, 1);
      chk("t1_fd", frame_done, 0);
    end
    @(negedge clk);
    chk("t1_end_fd", frame_done, 1);
    chk("t1_end_busy", busy, 0);
    chk("t1_end_en", en, 0);
    @(negedge clk);
    chk("t1_fd_once", frame_done, 0);

    // Empty mask: start ignored.
    tick();
    mask = 4'b0000; dwell = 8'd3;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_busy", busy, 0);
      chk("t3_en", en, 0);
    end

    // Dwell 0 on channel 2.
    tick();
    mask = 4'b0100; dwell = 8'd0;
    pulse_start();
    @(negedge clk);
    chk("t4_en1", en, 1);
    chk("t4_ab1", {A, B}, 2);
    @(negedge clk);
    chk("t4_en2", en, 0);
    chk("t4_ab2", {A, B}, 2);
    chk("t4_busy2", busy, 1);
    @(negedge clk);
    chk("t4_fd", frame_done, 1);
    chk("t4_busy3", busy, 0);

    // Continuous 1010/dwell 3: frames of 8 cycles, start while busy ignored.
    tick();
    mask = 4'b1010; dwell = 8'd3; continuous = 1'b1;
    pulse_start();
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      if (frame_done) fd_pos.push_back(n);
      if (n == 1) chk("t2_c1_ab", {A, B}, 1);
      if (n == 5) chk("t2_c5_ab", {A, B}, 3);
      if (n == 9) chk("t2_c9_ab", {A, B}, 1);
      start = (n == 3);
    end
    chk("t2_fd_count", fd_pos.size(), 3);
    if (fd_pos.size() == 3) begin
      chk("t2_fd_first", fd_pos[0], 9);
      chk("t2_fd_gap1", fd_pos[1] - fd_pos[0], 8);
      chk("t2_fd_gap2", fd_pos[2] - fd_pos[1], 8);
    end
    mask = 4'b0001; dwell = 8'd1;
    repeat (7) @(negedge clk);
    chk("t2_relatch_fd", frame_done, 1);
    chk("t2_relatch_en", en, 1);
    chk("t2_relatch_ab", {A, B}, 0);
    mask = 4'b0000;
    waited = 0;
    while (busy && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("t2_idle_on_zero_mask", busy, 0);
    chk("t2_idle_latency", waited, 2);
    continuous = 1'b0;

    // Stop on 2nd SCAN cycle of channel 1, with a simultaneous start.
    tick();
    mask = 4'b1111; dwell = 8'd3;
    pulse_start();
    repeat (5) @(posedge clk);
    #2;
    chk("t5_pre_en", en, 1);
    chk("t5_pre_ab", {A, B}, 1);
    stop = 1'b1; start = 1'b1;
    @(posedge clk);
    #2;
    stop = 1'b0; start = 1'b0;
    chk("t5_en", en, 0);
    chk("t5_ab", {A, B}, 0);
    chk("t5_busy", busy, 0);
    chk("t5_fd", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5_still_idle", busy, 0);
    chk("t5_no_fd", frame_done, 0);

    // Asynchronous reset mid-SCAN on channel 1.
    tick();
    mask = 4'b1111; dwell = 8'd4;
    pulse_start();
    repeat (6) @(posedge clk);
    #3;
    chk("t6_pre_en", en, 1);
    chk("t6_pre_ab", {A, B}, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_en", en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ab", {A, B}, 0);
    chk("t6_fd", frame_done, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_wait_busy", busy, 0);
      chk("t6_wait_en", en, 0);
    end
    tick();
    mask = 4'b0001; dwell = 8'd1;
    pulse_start();
    @(negedge clk);
    chk("t6_restart_en", en, 1);
    repeat (3) @(negedge clk);
    chk("t6_restart_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
